// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line DMA writer: FSM state encoding,
// status register bit positions and default width parameters.
package line_dma_pkg;

  localparam int DEF_DATA_W     = 128;
  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_BURST_W    = 8;
  localparam int DEF_MAX_BURST  = 16;
  localparam int DEF_FIFO_DEPTH = 64;

  // Remaining/word counters are derived from 32-bit byte values with the
  // 16-byte beat offset dropped.
  localparam int CNT_W = 28;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ABT     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_DATA,
    S_BURST,
    S_DONE
  } state_t;

endpackage

// File: rtl/line_dma_fifo.sv
// Show-ahead FIFO for the line DMA writer. rd_data always presents the
// oldest stored word; flush empties the FIFO in one cycle and has priority
// over push and pop in the same cycle.
module line_dma_fifo
  import line_dma_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int FCW   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic [FCW-1:0]    count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCW-1:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_count == FCW'(DEPTH));
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_push  = push && !full && !flush;
  assign w_pop   = pop && (r_count != '0) && !flush;

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + FCW'(1);
      else if (w_pop && !w_push) r_count <= r_count - FCW'(1);
    end
  end

endmodule

// File: rtl/line_dma_writer.sv
// Avalon-MM burst write master: buffers a 128-bit pixel stream in a FIFO
// and writes it to SDRAM as bursts of up to MAX_BURST beats.
// Optional macro LINE_DMA_RING_EN: ring-buffer mode (reload base/size at
// end of buffer, keep running until abort). Undefined: single-shot.
module line_dma_writer
  import line_dma_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BURST_W    = DEF_BURST_W,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         cfg_adr,
  input  logic [31:0]         cfg_buf_size,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [BURST_W-1:0]  avm_burstcount,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  output logic [31:0]         status,
  output logic                done_irq
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [CNT_W-1:0]    r_size;
  logic [CNT_W-1:0]    r_remain;
  logic [CNT_W-1:0]    r_words;
  logic [BURST_W-1:0]  r_blen;
  logic [BURST_W-1:0]  r_beat;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic                r_abt;
  logic                r_abort_pend;
  logic                r_done_irq;

  logic [FCW-1:0]      w_fifo_count;
  logic                w_fifo_full;
  logic [DATA_W-1:0]   w_fifo_rd;
  logic [BURST_W-1:0]  w_blen;
  logic                w_fifo_ok;
  logic                w_beat;
  logic                w_last;
  logic [CNT_W-1:0]    w_remain_after;
  logic                w_wrap;
  logic                w_aborting;
  logic                w_start_ok;
  logic                w_enter_done;
  logic                w_unused_bits;

  assign w_unused_bits  = ^{cfg_adr[3:0], cfg_buf_size[3:0]};

  assign s_ready        = !w_fifo_full;
  assign avm_write      = (r_state == S_BURST);
  assign avm_address    = r_cur_addr;
  assign avm_burstcount = r_blen;
  assign avm_writedata  = avm_write ? w_fifo_rd : '0;
  assign avm_byteenable = '1;
  assign done_irq       = r_done_irq;

  assign status[ST_BUSY]          = r_busy;
  assign status[ST_DONE]          = r_done;
  assign status[ST_OVF]           = r_ovf;
  assign status[ST_ABT]           = r_abt;
  assign status[31:ST_CNT_LSB]    = r_words;

  assign w_blen         = (r_remain >= CNT_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                          : r_remain[BURST_W-1:0];
  assign w_fifo_ok      = (32'(w_fifo_count) >= 32'(w_blen));
  assign w_beat         = avm_write && !avm_waitrequest;
  assign w_last         = w_beat && (r_beat == r_blen - BURST_W'(1));
  assign w_remain_after = r_remain - CNT_W'(r_blen);
  assign w_aborting     = abort || r_abort_pend;
  assign w_start_ok     = (r_state == S_IDLE) && start;
  assign w_enter_done   = (w_state_next == S_DONE) && (r_state != S_DONE);

  line_dma_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (r_state == S_DONE),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (w_beat),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .count   (w_fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; w_wrap marks an end-of-buffer reload in ring mode.
  always_comb begin
    w_state_next = r_state;
    w_wrap       = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_state_next = S_ARM;
      S_ARM: begin
        if (w_aborting || r_remain == '0) w_state_next = S_DONE;
        else                              w_state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (w_aborting)     w_state_next = S_DONE;
        else if (w_fifo_ok) w_state_next = S_BURST;
      end
      S_BURST: begin
        if (w_last) begin
          if (w_aborting) begin
            w_state_next = S_DONE;
          end else if (w_remain_after == '0) begin
`ifdef LINE_DMA_RING_EN
            w_wrap       = 1'b1;
            w_state_next = S_WAIT_DATA;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_state_next = S_WAIT_DATA;
          end
        end
      end
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Transfer datapath, progress counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base       <= '0;
      r_cur_addr   <= '0;
      r_size       <= '0;
      r_remain     <= '0;
      r_words      <= '0;
      r_blen       <= '0;
      r_beat       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_abt        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done_irq   <= 1'b0;
    end else begin
      r_done_irq <= 1'b0;
      if (w_start_ok) begin
        r_base       <= cfg_adr[ADDR_W+3:4];
        r_cur_addr   <= cfg_adr[ADDR_W+3:4];
        r_size       <= cfg_buf_size[31:4];
        r_remain     <= cfg_buf_size[31:4];
        r_words      <= '0;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_abt        <= 1'b0;
        r_abort_pend <= 1'b0;
      end
      if (abort && (r_state == S_ARM || r_state == S_WAIT_DATA || r_state == S_BURST))
        r_abort_pend <= 1'b1;
      if (r_state == S_WAIT_DATA && w_state_next == S_BURST) begin
        r_blen <= w_blen;
        r_beat <= '0;
      end
      if (w_beat) begin
        r_beat <= r_beat + BURST_W'(1);
        if (w_last) begin
          r_cur_addr <= w_wrap ? r_base : r_cur_addr + ADDR_W'(r_blen);
          r_remain   <= w_wrap ? r_size : w_remain_after;
          r_words    <= r_words + CNT_W'(r_blen);
        end
      end
      if (w_wrap) begin
        r_done     <= 1'b1;
        r_done_irq <= 1'b1;
      end
      if (w_enter_done) begin
        r_busy <= 1'b0;
        if (w_aborting) begin
          r_abt <= 1'b1;
        end else begin
          r_done     <= 1'b1;
          r_done_irq <= 1'b1;
        end
      end
      // Sticky overflow; a start in the same cycle wins.
      if (w_start_ok)                   r_ovf <= 1'b0;
      else if (s_valid && w_fifo_full)  r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_dma_writer.sv
// Directed testbench for line_dma_writer: an Avalon slave model records
// every accepted beat, bursts are checked for address/burstcount
// stability, and beat order/data are compared against the stream order.
`timescale 1ns/1ps
module tb_line_dma_writer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  cfg_adr = '0;
  logic [31:0]  cfg_buf_size = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [27:0]  avm_address;
  logic [7:0]   avm_burstcount;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic         avm_waitrequest = 1'b0;
  logic [31:0]  status;
  logic         done_irq;

  int checks = 0;
  int failures = 0;

  line_dma_writer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_adr         (cfg_adr),
    .cfg_buf_size    (cfg_buf_size),
    .start           (start),
    .abort           (abort),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .status          (status),
    .done_irq        (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int i);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(i);
    return {w, ~w, w ^ 32'hFFFF_0000, w + 32'h0000_1111};
  endfunction

  // Avalon slave model: drives waitrequest, records beats, checks stability.
  logic         wr_rand = 1'b0;
  logic [127:0] q_data[$];
  logic [27:0]  q_addr[$];
  logic [7:0]   q_bc[$];
  int           irq_cnt = 0;
  logic         in_b = 1'b0;
  logic [27:0]  b_addr = '0;
  logic [7:0]   b_bc = '0;
  int           b_left = 0;

  always @(negedge clk) begin
    avm_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (done_irq) irq_cnt++;
    if (avm_write) begin
      if (!in_b) begin
        in_b   = 1'b1;
        b_addr = avm_address;
        b_bc   = avm_burstcount;
        b_left = int'(avm_burstcount);
        $display("burst addr=0x%07h bc=%0d", avm_address, avm_burstcount);
      end else begin
        check("addr_stable", avm_address, b_addr);
        check("bc_stable", avm_burstcount, b_bc);
      end
      if (!avm_waitrequest) begin
        q_data.push_back(avm_writedata);
        q_addr.push_back(avm_address);
        q_bc.push_back(avm_burstcount);
        b_left--;
        if (b_left <= 0) in_b = 1'b0;
      end
    end
  end

  task automatic clear_log();
    q_data.delete();
    q_addr.delete();
    q_bc.delete();
    irq_cnt = 0;
  endtask

  task automatic preload(input int n, input int dbase);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      if (s_ready) begin
        s_valid = 1'b1;
        s_data  = mk(dbase + i);
        i++;
      end else begin
        s_valid = 1'b0;
      end
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("preload_count", i, n);
  endtask

  task automatic go(input logic [31:0] adr, input logic [31:0] size);
    @(negedge clk);
    cfg_adr      = adr;
    cfg_buf_size = size;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    $display("start adr=0x%08h size=%0d", adr, size);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (status[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_clear"}, status[0], 1'b0);
    @(negedge clk);
  endtask

  task automatic verify_beats(input string tag, input int n, input logic [27:0] base,
                              input int bc, input int wrap, input int dbase);
    check({tag, "_nbeats"}, q_data.size(), n);
    for (int k = 0; k < n && k < q_data.size(); k++) begin
      check({tag, "_addr"}, q_addr[k], base + 28'(((k / bc) * bc) % wrap));
      check({tag, "_bc"}, q_bc[k], bc);
      check({tag, "_data"}, q_data[k], mk(dbase + k));
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_status", status, 32'h0);
    check("rst_write", avm_write, 1'b0);
    check("rst_irq", done_irq, 1'b0);
    check("rst_be", avm_byteenable, 16'hFFFF);
    check("rst_ready", s_ready, 1'b1);
    check("rst_addr", avm_address, 28'h0);
    check("rst_bc", avm_burstcount, 8'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 512 B at 0x1000_0000, 32 words -> two bursts of 16
    clear_log();
    preload(32, 0);
    go(32'h1000_0000, 32'd512);
    check("t1_busy", status[0], 1'b1);
    wait_idle("t1", 500);
    verify_beats("t1", 32, 28'h100_0000, 16, 1 << 30, 0);
    check("t1_irq", irq_cnt, 1);
    check("t1_status", status, 32'h0000_0202);

    // 48 B -> single burst of 3
    clear_log();
    preload(3, 100);
    go(32'h0000_4000, 32'd48);
    wait_idle("t2", 200);
    verify_beats("t2", 3, 28'h000_0400, 3, 1 << 30, 100);
    check("t2_words", status[31:4], 28'd3);
    check("t2_done", status[1], 1'b1);

    // Random waitrequest during bursts
    clear_log();
    preload(32, 40);
    wr_rand = 1'b1;
    go(32'h0000_0100, 32'd512);
    wait_idle("t3", 1000);
    wr_rand = 1'b0;
    verify_beats("t3", 32, 28'h000_0010, 16, 1 << 30, 40);
    check("t3_status", status, 32'h0000_0202);

    // Abort at beat 5 of the first 16-beat burst
    clear_log();
    preload(32, 200);
    go(32'h0000_2000, 32'd512);
    begin
      int n = 0;
      while (q_data.size() < 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    pulse_abort();
    wait_idle("t4", 500);
    verify_beats("t4", 16, 28'h000_0200, 16, 1 << 30, 200);
    check("t4_status", status, 32'h0000_0108);

    // Overflow with no transfer running, cleared by start
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = mk(500 + i);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("t5_ovf_set", status[2], 1'b1);
    check("t5_full", s_ready, 1'b0);
    go(32'h0000_0000, 32'd0);
    check("t5_ovf_clr", status[2], 1'b0);
    wait_idle("t5", 100);
    check("t5_status", status, 32'h0000_0002);
    check("t5_flushed", s_ready, 1'b1);

`ifdef LINE_DMA_RING_EN
    // Ring mode: 256 B buffer, 48 words -> three wraps to base
    clear_log();
    preload(48, 300);
    go(32'h0300_0000, 32'd256);
    begin
      int n = 0;
      while (q_data.size() < 48 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    verify_beats("ring", 48, 28'h030_0000, 16, 16, 300);
    check("ring_irq", irq_cnt, 3);
    check("ring_busy", status[0], 1'b1);
    check("ring_done", status[1], 1'b1);
    check("ring_words", status[31:4], 28'd48);
    pulse_abort();
    wait_idle("ring", 100);
    check("ring_aborted", status[3], 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_dma_writer.md
# line_dma_writer

Avalon-MM burst write master that moves the line-scanner pixel stream into HPS SDRAM through the 128-bit FPGA-to-SDRAM port (`sdram0_*`). The block drives that port as its initiator. Software programs the buffer base (`dma_adr`) and byte size (`dma_buf_size`) and reads back progress through `dma_status`. Incoming 128-bit words are buffered in a FIFO and written out as fixed-maximum bursts until the buffer is full or the transfer is aborted.

## Interface
Parameters:
- `DATA_W`, 128, stream and Avalon data width.
- `ADDR_W`, 28, Avalon word address width.
- `BURST_W`, 8, burstcount width.
- `MAX_BURST`, 16, maximum beats per burst (1..2^(BURST_W-1)).
- `FIFO_DEPTH`, 64, input FIFO depth in words (power of 2, ≥ MAX_BURST).

Ports:
- `clk`  in  1  single clock (bus clock domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_adr`  in  32  buffer base byte address; bits [3:0] ignored.
- `cfg_buf_size`  in  32  buffer size in bytes; bits [3:0] ignored.
- `start`  in  1  one-cycle pulse that latches cfg and begins a transfer.
- `abort`  in  1  one-cycle pulse requesting termination.
- `s_data`  in  DATA_W  stream word.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  FIFO not full.
- `avm_address`  out  ADDR_W  word address.
- `avm_burstcount`  out  BURST_W  beats in current burst.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  DATA_W  beat data.
- `avm_byteenable`  out  DATA_W/8  always all ones.
- `avm_waitrequest`  in  1  slave stall.
- `status`  out  32  [0] busy, [1] done, [2] overflow, [3] aborted, [31:4] words written, 28 bits.
- `done_irq`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ARM, WAIT_DATA, BURST, DONE.
- IDLE: `start` latches `base = cfg_adr[31:4]` and `remain = cfg_buf_size[31:4]`, clears status bits [3:1] and the word count, then moves to ARM. In any other state `start` is ignored.
- ARM: lasts 1 cycle. If `remain == 0`, go to DONE. Otherwise go to WAIT_DATA.
- WAIT_DATA: `blen = min(MAX_BURST, remain)`. When `fifo_count >= blen`, go to BURST and drive `avm_address = cur_addr` and `avm_burstcount = blen`.
- BURST:
  - `avm_write` is held high.
  - Each beat pops one FIFO word when `avm_write && !avm_waitrequest`.
  - Address and burstcount stay stable for the whole burst.
  - After the last beat: `cur_addr += blen`, `remain -= blen`, `words += blen`. Go to DONE if `remain == 0` or an abort is pending; otherwise go to WAIT_DATA.
- DONE: pulse `done_irq` and set `done`, or set `aborted` if the transfer was aborted. Flush the FIFO and return to IDLE.
- `abort`:
  - In WAIT_DATA or ARM: go to DONE on the next cycle.
  - In BURST: latched as pending. The burst is always completed, because Avalon bursts cannot be truncated.
- Overflow: `s_valid && !s_ready` sets sticky `overflow`; the word is dropped. Cleared only by `start`.
- Words arriving while in IDLE are accepted into the FIFO and are flushed in DONE only.
- Address arithmetic is modulo 2^ADDR_W. A buffer that wraps past the top of the address space wraps silently.

## Timing
- Reset values:
  - All outputs are 0, including `avm_write`, `done_irq` and `status`.
  - Exceptions: `avm_byteenable` is all ones and `s_ready` is 1.
  - FSM state is IDLE and the FIFO is empty.
- `start` to ARM is 1 cycle. ARM to WAIT_DATA is 1 cycle.
- WAIT_DATA condition true in cycle N gives `avm_write` high in cycle N+1.
- A burst of B beats with no waitrequest takes B cycles. Each waitrequest cycle adds 1 cycle.
- `done_irq` is asserted in the cycle DONE is entered. Status bits update in the same cycle.
- FIFO is show-ahead: `avm_writedata` is valid whenever `avm_write` is high.
- A simultaneous FIFO push and pop leaves the count unchanged. Push at full is blocked by `s_ready = 0`.
- `reset_n` asserted mid-burst drops `avm_write` immediately (asynchronously).

## Configuration
- `LINE_DMA_RING_EN` defined: ring-buffer mode.
  - When `remain` reaches 0, the block reloads `cur_addr = base` and `remain` from the latched size.
  - It pulses `done_irq`, sets `done` and continues in WAIT_DATA.
  - `busy` stays high until `abort`.
  - The word count is cumulative modulo 2^28.
- Not defined: the block goes to DONE at end of buffer (single-shot).

## Structure
- `line_dma_pkg` holds:
  - the FSM state enum;
  - status bit index constants (`ST_BUSY=0`, `ST_DONE=1`, `ST_OVF=2`, `ST_ABT=3`, `ST_CNT_LSB=4`);
  - the default width constants.
- Sub-module `line_dma_fifo`: synchronous show-ahead FIFO with a `count` output and a `flush` input.

## Test plan
- Base 0x1000_0000, size 512 B, 32 words streamed → bursts of 16 at word addresses 0x100_0000 and 0x100_0010; `done_irq` once; status = 0x0000_0202.
- Size 48 B with MAX_BURST 16 → one burst with burstcount 3; words = 3.
- `avm_waitrequest` toggled randomly during bursts → address and burstcount stable, no beat lost or duplicated; data matches the input order.
- `abort` mid-burst at beat 5 of 16 → all 16 beats complete, then `aborted = 1`, `done = 0`, `busy = 0`.
- Source holds `s_valid` high while FIFO is full and no `start` has been issued → `overflow = 1`; after `start`, `overflow = 0`.
- With `LINE_DMA_RING_EN`, size 256 B and 48 words → 3 `done_irq` pulses, addresses wrap to base, `busy` stays 1; `abort` → idle.
